sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and sequencer for a shared single-port SRAM.
// One command in flight at a time; all outputs are registered.
module sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              err0,
  output logic              err1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds reqN and its command stable until it sees
  // the one-cycle gntN pulse; it may drop reqN or present a new command in
  // the following cycle. A req withdrawn before its gnt is never served.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RDATA = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t r_state;
  logic   r_last;
  logic   r_owner;
  logic   r_rd_pend;

  logic              w_any;
  logic              w_pick;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_legal;

  // Port that is not `last` wins a tie; a lone requester always wins.
  assign w_any   = req0 | req1;
  assign w_pick  = (req0 & req1) ? ~r_last : req1;
  assign w_we    = w_pick ? we1 : we0;
  assign w_addr  = w_pick ? addr1 : addr0;
  assign w_wdata = w_pick ? wdata1 : wdata0;
  assign w_legal = ({1'b0, w_addr} < DEPTH_L);

  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_rd_pend <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      ram_we  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner   <= w_pick;
            r_last    <= w_pick;
            ram_addr  <= w_addr;
            ram_wdata <= w_wdata;
            r_rd_pend <= w_legal & ~w_we;
            ram_we    <= w_legal & w_we;
            if (w_pick) begin
              gnt1 <= 1'b1;
              err1 <= ~w_legal;
            end else begin
              gnt0 <= 1'b1;
              err0 <= ~w_legal;
            end
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= r_rd_pend ? S_RDATA : S_IDLE;
        end
        S_RDATA: begin
          // SRAM data_out is valid this cycle; capture it for the owner only.
          if (r_owner) begin
            rdata1  <= ram_rdata;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= ram_rdata;
            rvalid0 <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model plus a transaction-level timing model
// of arbitration, grant, and read-return cycles.
module tb_sram_arbiter;

  localparam int AW = 4;
  localparam int DW = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    gap;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, err0, err1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:7];
  logic [DW-1:0] ref_mem [0:7];
  logic          m_last;
  logic [DW-1:0] e_rd0, e_rd1;
  cmd_t          q0[$], q1[$];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // 8-word SRAM with registered read port
  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_addr < 4'd8) mem[ram_addr[2:0]] <= ram_wdata;
    end else begin
      ram_rdata <= (ram_addr < 4'd8) ? mem[ram_addr[2:0]] : '0;
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_last = 1'b1;
    e_rd0 = '0;
    e_rd1 = '0;
  endtask

  // Drives the queued commands of both ports and checks every output cycle
  // against the transaction-level timing model.
  task automatic run_engine(input string name, input int budget);
    int   c = 0, free = 0;
    int   g_cyc = -1, rv_cyc = -1;
    logic g_port = 0, g_we = 0, g_err = 0, rv_port = 0, w;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_wdata = '0, rv_data = '0;
    logic act0 = 0, act1 = 0, r0, r1;
    int   cnt0 = 0, cnt1 = 0;
    cmd_t cur0 = '0, cur1 = '0, cw;
    logic [6:0] exp_f, got_f;
    while (1) begin
      if (c == rv_cyc) begin
        if (rv_port) e_rd1 = rv_data; else e_rd0 = rv_data;
      end
      exp_f = {c == g_cyc && !g_port, c == g_cyc && g_port,
               c == g_cyc && g_err && !g_port, c == g_cyc && g_err && g_port,
               c == rv_cyc && !rv_port, c == rv_cyc && rv_port,
               c == g_cyc && g_we && !g_err};
      got_f = {gnt0, gnt1, err0, err1, rvalid0, rvalid1, ram_we};
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++;
        $display("FAIL %s flags cyc=%0d got(g0g1e0e1v0v1we)=%b expected=%b", name, c, got_f, exp_f);
      end
      n_checks++;
      if (rdata0 !== e_rd0 || rdata1 !== e_rd1) begin
        n_fail++;
        $display("FAIL %s rdata cyc=%0d got=%h/%h expected=%h/%h", name, c, rdata0, rdata1, e_rd0, e_rd1);
      end
      if (c == g_cyc) begin
        n_checks++;
        if (ram_addr !== g_addr || ram_wdata !== g_wdata) begin
          n_fail++;
          $display("FAIL %s ram_bus cyc=%0d got=%h/%h expected=%h/%h", name, c, ram_addr, ram_wdata, g_addr, g_wdata);
        end
        if (g_port) act1 = 0; else act0 = 0;
      end
      if (!act0 && q0.size() > 0) begin cur0 = q0.pop_front(); act0 = 1; cnt0 = int'(cur0.gap); end
      if (!act1 && q1.size() > 0) begin cur1 = q1.pop_front(); act1 = 1; cnt1 = int'(cur1.gap); end
      r0 = act0 && cnt0 == 0;
      r1 = act1 && cnt1 == 0;
      if (act0 && cnt0 > 0) cnt0--;
      if (act1 && cnt1 > 0) cnt1--;
      req0 = r0; we0 = cur0.we; addr0 = cur0.addr; wdata0 = cur0.wdata;
      req1 = r1; we1 = cur1.we; addr1 = cur1.addr; wdata1 = cur1.wdata;
      if (c >= free && (r0 || r1)) begin
        w = (r0 && r1) ? !m_last : r1;
        m_last = w;
        cw = w ? cur1 : cur0;
        g_cyc = c + 1; g_port = w; g_we = cw.we;
        g_addr = cw.addr; g_wdata = cw.wdata; g_err = (cw.addr >= 4'd8);
        if (g_err) free = c + 2;
        else if (cw.we) begin ref_mem[cw.addr[2:0]] = cw.wdata; free = c + 2; end
        else begin
          rv_cyc = c + 3; rv_port = w; rv_data = ref_mem[cw.addr[2:0]]; free = c + 3;
        end
      end
      if (!act0 && !act1 && q0.size() == 0 && q1.size() == 0 &&
          c >= free && c > g_cyc && c > rv_cyc) break;
      if (c >= budget) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout cyc=%0d got=busy expected=done", name, c);
        q0.delete(); q1.delete();
        req0 = 0; req1 = 0;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic test_reset();
    logic [13:0] got;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = 4'($urandom); addr1 = 4'($urandom);
      wdata0 = 4'($urandom); wdata1 = 4'($urandom);
      got = {gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata0, rdata1};
      n_checks++;
      if (got !== '0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs got=%h/%b/%h/%h expected=0", got, ram_we, ram_addr, ram_wdata);
      end
    end
    req0 = 0; req1 = 0;
    rst_n = 1'b1;
    m_last = 1'b1; e_rd0 = '0; e_rd1 = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({gnt0, gnt1, ram_we} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_idle got=%b expected=000", {gnt0, gnt1, ram_we});
      end
    end
  endtask

  task automatic test_write_read_p0();
    q0.push_back('{1'b1, 4'd4, 4'd9, 3'd0});
    q0.push_back('{1'b0, 4'd4, 4'd0, 3'd0});
    run_engine("wr_rd_p0", 40);
    n_checks++;
    if (rdata0 !== 4'd9) begin
      n_fail++; $display("FAIL wr_rd_p0_data got=%h expected=9", rdata0);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    q0.push_back('{1'b1, 4'd2, 4'd10, 3'd0});
    q1.push_back('{1'b0, 4'd2, 4'd0, 3'd0});
    run_engine("simult", 40);
    n_checks++;
    if (rdata1 !== 4'd10 || rdata0 !== 4'd0) begin
      n_fail++; $display("FAIL simult_data got=%h/%h expected=0/a", rdata0, rdata1);
    end
  endtask

  task automatic test_fairness();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 4'd4, 4'd0, 3'd0});
      q1.push_back('{1'b0, 4'd2, 4'd0, 3'd0});
    end
    run_engine("fair", 60);
    n_checks++;
    if (rdata0 !== 4'd9 || rdata1 !== 4'd10) begin
      n_fail++; $display("FAIL fair_data got=%h/%h expected=9/a", rdata0, rdata1);
    end
  endtask

  task automatic test_out_of_range();
    q1.push_back('{1'b1, 4'd12, 4'd5, 3'd0});
    q1.push_back('{1'b0, 4'd4, 4'd0, 3'd0});
    run_engine("oor", 40);
    n_checks++;
    if (rdata1 !== 4'd9) begin
      n_fail++; $display("FAIL oor_data got=%h expected=9", rdata1);
    end
  endtask

  task automatic test_reset_during_read();
    req0 = 1; we0 = 0; addr0 = 4'd4;
    @(posedge clk); #1;
    n_checks++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL rst_rd_gnt got=%b expected=1", gnt0);
    end
    req0 = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rvalid0 !== 1'b0 || rdata0 !== '0) begin
        n_fail++; $display("FAIL rst_rd_drop got=%b/%h expected=0/0", rvalid0, rdata0);
      end
    end
    rst_n = 1'b1;
    m_last = 1'b1; e_rd0 = '0; e_rd1 = '0;
    q0.push_back('{1'b0, 4'd2, 4'd0, 3'd0});
    run_engine("rst_rd_after", 40);
    n_checks++;
    if (rdata0 !== 4'd10) begin
      n_fail++; $display("FAIL rst_rd_after_data got=%h expected=a", rdata0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      q0.push_back('{1'($urandom), 4'($urandom_range(0, 9)), 4'($urandom), 3'($urandom_range(0, 3))});
      q1.push_back('{1'($urandom), 4'($urandom_range(0, 9)), 4'($urandom), 3'($urandom_range(0, 3))});
    end
    run_engine("random", 2000);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_last = 1'b1; e_rd0 = '0; e_rd1 = '0;
    test_reset();
    test_write_read_p0();
    test_simultaneous();
    test_fairness();
    test_out_of_range();
    test_reset_during_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
